mem_bus_arbiter: RTL

//  Shares the single memory port between the core control/datapath (requester "core") and the debug

---
 rtl/mem_bus_pkg.sv | 29 ++
 rtl/mem_bus_arb_timer.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types for the memory-bus arbiter.
//   mem_req_t   : one requester's forwarded request {read, write, addr, wdata, be}
//   arb_state_e : arbiter FSM states
//   REQ_CORE / REQ_DBG : requester indices into the request array
// The struct fields are sized by MEM_ADDR_W / MEM_DATA_W; the arbiter's
// ADDR_W / DATA_W must not exceed them.
package mem_bus_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  localparam int REQ_CORE = 0;
  localparam int REQ_DBG  = 1;
  localparam int NUM_REQ  = 2;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_CORE = 2'd1,
    GRANT_DBG  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/mem_bus_arb_timer.sv
// mem_bus_arb_timer: stall watchdog for a granted transaction.
//   clk, rst_n : clock / async active-low reset
//   clear      : zero the count (held while the arbiter is idle)
//   enable     : count this cycle (arbiter is in a grant state)
//   expired    : enable && count == TIMEOUT-1, i.e. the TIMEOUT-th grant cycle
// TIMEOUT = 0 disables the watchdog (expired tied low). The count saturates
// at TIMEOUT rather than wrapping.
module mem_bus_arb_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = clk ^ rst_n ^ clear ^ enable;
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               cnt_q <= '0;
        else if (clear)                           cnt_q <= '0;
        else if (enable && cnt_q != CW'(TIMEOUT)) cnt_q <= cnt_q + CW'(1);
      end

      assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the core and the debug
// module's system-bus access. One hold-until-complete transaction at a time,
// with a mandatory idle bubble between grants.
// Ports (r = core | dbg):
//   clk, rst_n                          clock / async active-low reset
//   r_read, r_write, r_addr, r_wdata, r_be   requester inputs, held until r_complete
//   r_rdata, r_complete, r_error        response to the owner only
//   mem_read/write/addr/wdata/be        owner's request forwarded to memory
//   mem_rdata, mem_complete             memory response
//   dbg_owns_bus                        registered: dbg is the current owner
// Config: define MEM_BUS_ARBITER_RR_EN for round-robin arbitration;
// otherwise dbg has fixed priority so a halting debugger cannot starve.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_read,
  input  logic                core_write,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_be,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_complete,
  output logic                core_error,
  input  logic                dbg_read,
  input  logic                dbg_write,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_be,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                dbg_complete,
  output logic                dbg_error,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_complete,
  output logic                dbg_owns_bus
);
  localparam int BE_W = DATA_W / 8;

  mem_req_t   req [NUM_REQ];
  mem_req_t   sel;
  arb_state_e state_q, state_d;
  logic       req_core_v, req_dbg_v, pick_dbg;
  logic       granted, tmo, timeout_err, done;

  always_comb begin
    req[REQ_CORE] = '{read: core_read, write: core_write,
                      addr: MEM_ADDR_W'(core_addr), wdata: MEM_DATA_W'(core_wdata),
                      be: MEM_BE_W'(core_be)};
    req[REQ_DBG]  = '{read: dbg_read, write: dbg_write,
                      addr: MEM_ADDR_W'(dbg_addr), wdata: MEM_DATA_W'(dbg_wdata),
                      be: MEM_BE_W'(dbg_be)};
  end

  assign req_core_v = req[REQ_CORE].read | req[REQ_CORE].write;
  assign req_dbg_v  = req[REQ_DBG].read  | req[REQ_DBG].write;
  assign granted    = (state_q != IDLE);

`ifdef MEM_BUS_ARBITER_RR_EN
  // last_dbg_q: 1 when dbg was the last requester granted. Resets to core,
  // so the first simultaneous request goes to dbg.
  logic last_dbg_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 last_dbg_q <= 1'b0;
    else if (state_q == IDLE && state_d != IDLE) last_dbg_q <= (state_d == GRANT_DBG);
  end
  assign pick_dbg = req_dbg_v && (!req_core_v || !last_dbg_q);
`else
  assign pick_dbg = req_dbg_v;
`endif

  mem_bus_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!granted),
    .enable  (granted),
    .expired (tmo)
  );

  // A memory completion in the timeout cycle wins over the error.
  assign timeout_err = tmo && !mem_complete;
  assign done        = mem_complete || tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grants always return through IDLE, giving the owner a cycle to drop its request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_dbg)        state_d = GRANT_DBG;
        else if (req_core_v) state_d = GRANT_CORE;
      end
      GRANT_CORE, GRANT_DBG: if (done) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    sel = '0;
    if (state_q == GRANT_CORE) sel = req[REQ_CORE];
    if (state_q == GRANT_DBG)  sel = req[REQ_DBG];
    if (timeout_err)           sel = '0;   // abandon the access on timeout

    mem_read  = sel.read && !sel.write;    // read+write together is a write
    mem_write = sel.write;
    mem_addr  = ADDR_W'(sel.addr);
    mem_wdata = DATA_W'(sel.wdata);
    mem_be    = BE_W'(sel.be);

    core_complete = (state_q == GRANT_CORE) && done;
    core_error    = (state_q == GRANT_CORE) && timeout_err;
    core_rdata    = ((state_q == GRANT_CORE) && mem_complete) ? mem_rdata : '0;
    dbg_complete  = (state_q == GRANT_DBG) && done;
    dbg_error     = (state_q == GRANT_DBG) && timeout_err;
    dbg_rdata     = ((state_q == GRANT_DBG) && mem_complete) ? mem_rdata : '0;
  end

  assign dbg_owns_bus = (state_q == GRANT_DBG);
endmodule
